// File: rtl/traffic_light_display.sv
// Lamp drive and two-digit multiplexed 7-segment readout for the traffic-light controller.
// Optional green-lamp blink in the final seconds of GREEN is enabled by defining GREEN_BLINK_EN.
module traffic_light_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic [3:0] count_time,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green
);

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_YELLOW = 2'b01,
        ST_GREEN  = 2'b10,
        ST_NONE   = 2'b11
    } light_state_t;

    localparam logic [5:0] FILTER_RESET = 6'b110000;
    localparam logic [6:0] SEG_DASH     = 7'h40;
    localparam logic [6:0] SEG_BLANK    = 7'h00;
    localparam logic [6:0] SEG_ONE      = 7'h06;

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("traffic_light_display: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("traffic_light_display: BLINK_DIV must be at least 2");
    end

    logic [5:0]        s1;
    logic [5:0]        s2;
    light_state_t      d_state;
    logic [3:0]        d_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic              digit;
    logic              tens;
    logic [3:0]        ones;
    logic              green_on;
    logic [6:0]        seg_next;
    logic [1:0]        an_next;
    logic              red_next;
    logic              yellow_next;
    logic              green_next;

    // Inputs arrive from the 1 Hz domain; only a value seen on two consecutive edges is displayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= FILTER_RESET;
            s2      <= FILTER_RESET;
            d_state <= ST_NONE;
            d_cnt   <= 4'd0;
        end else begin
            s1 <= {state, count_time};
            s2 <= s1;
            if (s1 == s2) begin
                d_state <= light_state_t'(s2[5:4]);
                d_cnt   <= s2[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= ~digit;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

`ifdef GREEN_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign green_on = (d_cnt <= 4'd3) ? blink_ph : 1'b1;
`else
    assign green_on = 1'b1;
`endif

    function automatic logic [6:0] digit_code(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    always_comb begin
        tens = (d_cnt >= 4'd10);
        ones = tens ? (d_cnt - 4'd10) : d_cnt;
    end

    // Tens digit is blanked rather than showing a leading zero; its enable stays asserted.
    always_comb begin
        seg_next    = SEG_BLANK;
        an_next     = digit ? 2'b10 : 2'b01;
        red_next    = 1'b0;
        yellow_next = 1'b0;
        green_next  = 1'b0;
        if (d_state == ST_NONE) begin
            seg_next = SEG_DASH;
        end else if (digit) begin
            seg_next = tens ? SEG_ONE : SEG_BLANK;
        end else begin
            seg_next = digit_code(ones);
        end
        case (d_state)
            ST_RED:    red_next    = 1'b1;
            ST_YELLOW: yellow_next = 1'b1;
            ST_GREEN:  green_next  = green_on;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg         <= SEG_BLANK;
            an          <= 2'b00;
            lamp_red    <= 1'b0;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
        end else begin
            seg         <= seg_next;
            an          <= an_next;
            lamp_red    <= red_next;
            lamp_yellow <= yellow_next;
            lamp_green  <= green_next;
        end
    end

endmodule

// File: tb/tb_traffic_light_display.sv
// Scoreboard bench for traffic_light_display: expected outputs come from a cycle-indexed
// reference model of the display rules and are checked by an independent monitor.
module tb_traffic_light_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] NONE   = 2'b11;

    localparam logic [6:0] DIGIT_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       red;
        logic       yellow;
        logic       green;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = GREEN;
    logic [3:0] count_time = 4'd15;
    logic [6:0] seg;
    logic [1:0] an;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;

    out_t       expQ[$];
    logic [5:0] hist[$];
    logic [5:0] shownValue;
    int         edgeNum;
    int         checks = 0;
    int         passed = 0;

    traffic_light_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .count_time  (count_time),
        .seg         (seg),
        .an          (an),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green)
    );

    always #5 clk = ~clk;

    // Output after post-reset edge n, given the value currently on display.
    function automatic out_t modelOutput(input int n, input logic [5:0] shown);
        out_t o;
        int   cnt;
        bit   tensSlot;
        bit   greenOn;
        cnt      = int'(shown[3:0]);
        tensSlot = (((n - 1) / SCAN_DIV) % 2) == 1;
        o        = '0;
        o.an     = tensSlot ? 2'b10 : 2'b01;
        if (shown[5:4] == NONE) begin
            o.seg = 7'h40;
        end else begin
            if (tensSlot) o.seg = (cnt >= 10) ? 7'h06 : 7'h00;
            else          o.seg = DIGIT_SEG[cnt % 10];
            greenOn = 1'b1;
`ifdef GREEN_BLINK_EN
            if (cnt <= 3) greenOn = (((n - 1) / BLINK_DIV) % 2) == 0;
`endif
            o.red    = (shown[5:4] == RED);
            o.yellow = (shown[5:4] == YELLOW);
            o.green  = (shown[5:4] == GREEN) && greenOn;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input out_t expected);
        out_t actual;
        actual = '{seg: seg, an: an, red: lamp_red, yellow: lamp_yellow, green: lamp_green};
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s @%0t: got seg=%h an=%b ryg=%b%b%b, expected seg=%h an=%b ryg=%b%b%b",
                     name, $time, actual.seg, actual.an, actual.red, actual.yellow, actual.green,
                     expected.seg, expected.an, expected.red, expected.yellow, expected.green);
        end
    endtask

    task automatic resetModel();
        hist.delete();
        hist.push_back(6'b110000);
        hist.push_back(6'b110000);
        shownValue = 6'b110000;
        edgeNum    = 0;
        expQ.delete();
    endtask

    // Hold one input value for a number of edges; each edge pushes its expected output.
    task automatic applyStimulus(input logic [1:0] st, input logic [3:0] ct, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            state      = st;
            count_time = ct;
            @(posedge clk);
            edgeNum++;
            hist.push_back({st, ct});
            if (edgeNum >= 2 && hist[edgeNum - 2] == hist[edgeNum - 1])
                shownValue = hist[edgeNum - 2];
            expQ.push_back(modelOutput(edgeNum, shownValue));
            #1;
        end
    endtask

    task automatic randomPhase(input int cycles);
        int remaining;
        int len;
        remaining = cycles;
        while (remaining > 0) begin
            len = int'($urandom_range(1, 6));
            if (len > remaining) len = remaining;
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), len);
            remaining -= len;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && expQ.size() > 0) begin
            checkOutput("scan", expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        @(negedge clk);
        checkOutput("reset_state", '0);
        @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(GREEN, 4'd15, 20);
        applyStimulus(RED, 4'd7, 16);
        applyStimulus(YELLOW, 4'd5, 8);
        applyStimulus(RED, 4'd0, 1);
        applyStimulus(YELLOW, 4'd5, 10);
        applyStimulus(NONE, 4'd9, 12);
        applyStimulus(GREEN, 4'd2, 28);
        applyStimulus(GREEN, 4'd4, 16);
        applyStimulus(GREEN, 4'd10, 10);
        randomPhase(300);

        applyStimulus(GREEN, 4'd12, 6);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", '0);
        resetModel();
        @(posedge clk);
        #1 checkOutput("reset_held", '0);
        reset = 1'b0;
        applyStimulus(GREEN, 4'd12, 16);
        randomPhase(150);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expected outputs never compared, required 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
